// File: rtl/stream_fifo.sv
// stream_fifo: single-clock first-word-fall-through FIFO with valid/ready
// handshakes on both sides, synchronous flush, occupancy count,
// almost_full threshold and a sticky overflow flag.
module stream_fifo #(
  parameter int D_WIDTH  = 6,
  parameter int A_WIDTH  = 2,
  parameter int AF_LEVEL = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  input  logic               down_ready,
  input  logic               flush,
  output logic [A_WIDTH:0]   count,
  output logic               almost_full,
  output logic               overflow
);

  localparam int             DEPTH   = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0] DEPTH_C = (A_WIDTH + 1)'(DEPTH);
  localparam logic [A_WIDTH:0] AF_C    = (A_WIDTH + 1)'(AF_LEVEL);

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               push, pop;

  // Handshake decode. up_ready is gated by rst so the FIFO refuses words
  // while held in reset, yet is ready immediately after release.
  assign up_ready    = rst && (count_q != DEPTH_C) && !flush;
  assign down_valid  = (count_q != '0);
  assign down_data   = mem_q[rd_ptr_q];
  assign almost_full = (count_q >= AF_C);
  assign overflow    = overflow_q;
  assign count       = count_q;
  assign push        = up_valid && up_ready;
  assign pop         = down_valid && down_ready && !flush;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (up_valid && (count_q == DEPTH_C) && !flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage written on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count/pointers alone define validity.
    if (push) mem_q[wr_ptr_q] <= up_data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo at default parameters, plus a randomised
// scoreboard run on a second instance with D_WIDTH=8, A_WIDTH=4, AF_LEVEL=12.
module tb_stream_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: default parameters
  logic [5:0] a_up_data;
  logic       a_up_valid, a_up_ready;
  logic [5:0] a_down_data;
  logic       a_down_valid, a_down_ready, a_flush;
  logic [2:0] a_count;
  logic       a_almost_full, a_overflow;

  stream_fifo u_dut_a (
    .clk(clk), .rst(rst),
    .up_data(a_up_data), .up_valid(a_up_valid), .up_ready(a_up_ready),
    .down_data(a_down_data), .down_valid(a_down_valid), .down_ready(a_down_ready),
    .flush(a_flush), .count(a_count), .almost_full(a_almost_full), .overflow(a_overflow)
  );

  // Instance B: wider, deeper
  logic [7:0] b_up_data;
  logic       b_up_valid, b_up_ready;
  logic [7:0] b_down_data;
  logic       b_down_valid, b_down_ready, b_flush;
  logic [4:0] b_count;
  logic       b_almost_full, b_overflow;

  stream_fifo #(.D_WIDTH(8), .A_WIDTH(4), .AF_LEVEL(12)) u_dut_b (
    .clk(clk), .rst(rst),
    .up_data(b_up_data), .up_valid(b_up_valid), .up_ready(b_up_ready),
    .down_data(b_down_data), .down_valid(b_down_valid), .down_ready(b_down_ready),
    .flush(b_flush), .count(b_count), .almost_full(b_almost_full), .overflow(b_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sb_q[$];

  initial begin
    a_up_data = '0; a_up_valid = 1'b0; a_down_ready = 1'b0; a_flush = 1'b0;
    b_up_data = '0; b_up_valid = 1'b0; b_down_ready = 1'b0; b_flush = 1'b0;

    // Reset state
    #3;
    check("rst_count",      64'(a_count), 64'd0);
    check("rst_down_valid", 64'(a_down_valid), 64'd0);
    check("rst_up_ready",   64'(a_up_ready), 64'd0);
    check("rst_almost_full",64'(a_almost_full), 64'd0);
    check("rst_overflow",   64'(a_overflow), 64'd0);
    check("rst_b_up_ready", 64'(b_up_ready), 64'd0);
    step();
    rst = 1'b1;
    #1;
    check("release_up_ready", 64'(a_up_ready), 64'd1);

    // Fill with 0x01..0x04, no draining
    for (int i = 1; i <= 4; i++) begin
      a_up_data  = 6'(i);
      a_up_valid = 1'b1;
      step();
      check("fill_count", 64'(a_count), 64'(i));
      check("fill_af",    64'(a_almost_full), (i >= 3) ? 64'd1 : 64'd0);
      check("fill_head",  64'(a_down_data), 64'h01);
      check("fill_dvalid",64'(a_down_valid), 64'd1);
    end
    check("full_up_ready", 64'(a_up_ready), 64'd0);

    // Offer 0x3F to the full FIFO for one cycle
    a_up_data = 6'h3F;
    step();
    a_up_valid = 1'b0;
    check("ovf_set",   64'(a_overflow), 64'd1);
    check("ovf_count", 64'(a_count), 64'd4);
    check("ovf_head",  64'(a_down_data), 64'h01);
    step();
    check("ovf_sticky", 64'(a_overflow), 64'd1);

    // Drain: 0x01..0x04 in order, 0x3F never appears
    a_down_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", 64'(a_down_data), 64'(i));
      step();
      check("drain_count", 64'(a_count), 64'(4 - i));
    end
    check("drain_empty", 64'(a_down_valid), 64'd0);
    check("drain_af",    64'(a_almost_full), 64'd0);

    // Streaming 0x00..0x3F, push and pop every cycle after the first
    a_up_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a_up_data = 6'(i);
      step();
      check("stream_data",  64'(a_down_data), 64'(i));
      check("stream_count", 64'(a_count), 64'd1);
    end
    a_up_valid = 1'b0;
    step();
    check("stream_end_count", 64'(a_count), 64'd0);
    a_down_ready = 1'b0;

    // Flush with concurrent push and pop at count=2
    a_up_valid = 1'b1;
    a_up_data  = 6'h0A; step();
    a_up_data  = 6'h0B; step();
    check("preflush_count", 64'(a_count), 64'd2);
    a_flush = 1'b1; a_up_data = 6'h0C; a_down_ready = 1'b1;
    #1;
    check("flush_up_ready", 64'(a_up_ready), 64'd0);
    check("flush_af_indep", 64'(a_almost_full), 64'd0);
    step();
    a_flush = 1'b0; a_up_valid = 1'b0; a_down_ready = 1'b0;
    check("flush_count",  64'(a_count), 64'd0);
    check("flush_dvalid", 64'(a_down_valid), 64'd0);
    a_up_valid = 1'b1; a_up_data = 6'h0D;
    step();
    a_up_valid = 1'b0;
    check("postflush_head",  64'(a_down_data), 64'h0D);
    check("postflush_count", 64'(a_count), 64'd1);
    a_down_ready = 1'b1;
    step();
    a_down_ready = 1'b0;
    check("postflush_empty", 64'(a_count), 64'd0);

    // Asynchronous reset while holding three words
    a_up_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_up_data = 6'(8'h21 + i);
      step();
    end
    a_up_valid = 1'b0;
    check("prerst_count", 64'(a_count), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_dvalid",  64'(a_down_valid), 64'd0);
    check("async_rst_count",   64'(a_count), 64'd0);
    check("async_rst_overflow",64'(a_overflow), 64'd0);
    check("async_rst_up_ready",64'(a_up_ready), 64'd0);
    step();
    rst = 1'b1;
    #1;
    check("rerelease_dvalid", 64'(a_down_valid), 64'd0);
    a_up_valid = 1'b1; a_up_data = 6'h15;
    step();
    a_up_valid = 1'b0;
    check("rerelease_data",  64'(a_down_data), 64'h15);
    check("rerelease_count", 64'(a_count), 64'd1);

    // Random traffic on instance B against a queue model
    for (int cyc = 0; cyc < 800; cyc++) begin
      int vt, rt;
      vt = (cyc < 400) ? 3 : 1;
      rt = (cyc < 400) ? 1 : 3;
      b_up_valid   = ($urandom_range(0, 3) < vt);
      b_down_ready = ($urandom_range(0, 3) < rt);
      b_up_data    = 8'($urandom);
      #1;
      check("b_count",    64'(b_count), 64'(sb_q.size()));
      check("b_af",       64'(b_almost_full), (sb_q.size() >= 12) ? 64'd1 : 64'd0);
      check("b_up_ready", 64'(b_up_ready), (sb_q.size() < 16) ? 64'd1 : 64'd0);
      check("b_dvalid",   64'(b_down_valid), (sb_q.size() != 0) ? 64'd1 : 64'd0);
      if (b_down_valid && b_down_ready && sb_q.size() != 0) begin
        check("b_data", 64'(b_down_data), 64'(sb_q[0]));
        void'(sb_q.pop_front());
      end
      if (b_up_valid && b_up_ready) sb_q.push_back(b_up_data);
      step();
    end
    b_up_valid = 1'b0;
    b_down_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      check("b_drain_count", 64'(b_count), 64'(sb_q.size()));
      if (b_down_valid && sb_q.size() != 0) begin
        check("b_drain_data", 64'(b_down_data), 64'(sb_q[0]));
        void'(sb_q.pop_front());
      end
      step();
    end
    check("b_final_count", 64'(b_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
